rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL have parameter S, default 3, the select width, giving N = 2**S requesters.
REQ-002 The block SHALL have parameter T, default 8, the data width per requester.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, N, per-requester request; bit i means in slice i holds valid data.
REQ-006 The block SHALL have port in, input, N*T, packed requester data; requester i occupies bits [(i+1)*T-1 : i*T].
REQ-007 The block SHALL have port grant, output, N, one-hot combinational acceptance; bit i high means slice i is consumed this cycle.
REQ-008 The block SHALL have port ctrl, output, S, registered index of the requester whose data is in out.
REQ-009 The block SHALL have port out, output, T, registered selected data.
REQ-010 The block SHALL have port out_valid, output, 1, out holds an unconsumed word.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts out this cycle when out_valid is high.

Function
REQ-012 The block SHALL implement a two-state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 A load SHALL occur in a cycle where |req is high and (state is EMPTY or out_ready is high).
REQ-014 The winner SHALL be the first index with req high, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (round robin, wrap mod N).
REQ-015 On a load, grant SHALL be one-hot at the winner in the same cycle; otherwise grant SHALL be all zero.
REQ-016 On a load, at the next edge: out = in slice of winner, ctrl = winner, out_valid = 1, ptr = (winner+1) mod N.
REQ-017 Latency from granted request to out_valid SHALL be exactly one cycle.
REQ-018 In FULL with out_ready high and a load, out SHALL be replaced back-to-back; sustained throughput is one word per cycle.
REQ-019 In FULL with out_ready high and no req, the next state SHALL be EMPTY; out and ctrl SHALL hold their last values.
REQ-020 In FULL with out_ready low, out, ctrl, ptr and out_valid SHALL hold; grant SHALL be zero regardless of req.
REQ-021 In EMPTY with no req, all registers SHALL hold.
REQ-022 out_ready SHALL be ignored while out_valid is low.
REQ-023 A single persistent requester SHALL win every load; with all N requesting, grants SHALL cycle 0,1,...,N-1,0.
REQ-024 Requesters SHALL keep req and data stable until granted; the block does not register req.

Reset
REQ-025 While reset is high: out_valid = 0, out = 0, ctrl = 0, ptr = 0, state = EMPTY, grant = 0.
REQ-026 Reset asserted mid-transfer SHALL drop out_valid immediately (asynchronously) and discard the held word.
REQ-027 The first load after reset deassertion SHALL search from index 0.

Structure
REQ-028 No shared package is required; S and T are module parameters and the EMPTY/FULL encoding is local.
REQ-029 Data selection SHALL instantiate the existing recurse_mux (parameters S, T) driven by the combinational winner index.
REQ-030 The round-robin priority search SHALL be a single combinational function or block inside rr_mux_arbiter.

Verification
REQ-031 Parameters S=2, T=8; reset pulse mid-run -> out_valid, out, ctrl go 0 at once; first load after release searches from index 0.
REQ-032 req=0001, in slice0=0xA5, out_ready=1 -> grant=0001 same cycle; next cycle out=0xA5, ctrl=0, out_valid=1.
REQ-033 req=1111 held, out_ready=1, slices 0x10,0x11,0x12,0x13 -> ctrl sequence 0,1,2,3,0 on consecutive cycles, out tracks slice.
REQ-034 FULL with out=0x11, out_ready=0 for 3 cycles, req=1111 -> grant=0000, out=0x11 held; out_ready=1 -> grant=0100 (ptr=2).
REQ-035 ptr=3, req=0101 -> grant=0001 (wrap past 3); next load with req=0101 -> grant=0100.
REQ-036 FULL, out_ready=1, req=0000 -> out_valid=0 next cycle, out and ctrl unchanged.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared defaults for the round-robin mux arbiter.
// Select width S gives 2**S requesters of T bits each.
package rr_mux_arbiter_pkg;
  localparam int DEF_S = 3;
  localparam int DEF_T = 8;
endpackage

// File: rtl/recurse_mux.sv
// Recursive 2**S:1 mux of T-bit slices.
// Built as a binary tree of 2:1 muxes, MSB of sel at the root.
module recurse_mux #(
  parameter int S = 3,
  parameter int T = 8
) (
  input  logic [S-1:0]          sel,
  input  logic [(2**S)*T-1:0]   in,
  output logic [T-1:0]          out
);

  localparam int H = (2**(S-1)) * T;

  if (S == 1) begin : g_base
    assign out = sel[0] ? in[2*T-1:T] : in[T-1:0];
  end else begin : g_rec
    logic [T-1:0] lo;
    logic [T-1:0] hi;

    recurse_mux #(
      .S(S-1),
      .T(T)
    ) u_lo (
      .sel(sel[S-2:0]),
      .in (in[H-1:0]),
      .out(lo)
    );

    recurse_mux #(
      .S(S-1),
      .T(T)
    ) u_hi (
      .sel(sel[S-2:0]),
      .in (in[2*H-1:H]),
      .out(hi)
    );

    assign out = sel[S-1] ? hi : lo;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with a one-word registered output stage.
// grant is combinational; out/ctrl/out_valid are registered.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int S = DEF_S,
  parameter int T = DEF_T
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2**S-1:0]    req,
  input  logic [(2**S)*T-1:0] in,
  output logic [2**S-1:0]    grant,
  output logic [S-1:0]       ctrl,
  output logic [T-1:0]       out,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int N = 2**S;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [S-1:0] ptr_q, ptr_d;
  logic [S-1:0] ctrl_q, ctrl_d;
  logic [T-1:0] out_q, out_d;
  logic [S-1:0] win;
  logic [S-1:0] idx;
  logic [T-1:0] mux_out;
  logic         found;
  logic         load;

  // First requester at or after ptr, wrapping mod N.
  always_comb begin
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = ptr_q + S'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  recurse_mux #(
    .S(S),
    .T(T)
  ) u_mux (
    .sel(win),
    .in (in),
    .out(mux_out)
  );

  assign load = !reset && found &&
                (state_q == EMPTY || out_ready);

  always_comb begin
    grant = '0;
    if (load) grant = N'(1) << win;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ctrl_d  = ctrl_q;
    out_d   = out_q;
    if (load) begin
      state_d = FULL;
      ptr_d   = win + S'(1);
      ctrl_d  = win;
      out_d   = mux_out;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      ctrl_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ctrl_q  <= ctrl_d;
      out_q   <= out_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign ctrl      = ctrl_q;
  assign out       = out_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter (S=2, T=8).
// Driver queues expected words; negedge monitor checks handoffs.
module tb_rr_mux_arbiter;

  localparam int S = 2;
  localparam int T = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*T-1:0] din = '0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   grant;
  logic [S-1:0]   ctrl;
  logic [T-1:0]   dout;
  logic           out_valid;

  int n_chk = 0;
  int n_fail = 0;
  logic [S+T-1:0] exp_q[$];
  logic [S+T-1:0] mon_e;

  rr_mux_arbiter #(
    .S(S),
    .T(T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .in       (din),
    .grant    (grant),
    .ctrl     (ctrl),
    .out      (dout),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive after the edge, check combinational grant,
  // queue the word the grant should produce.
  task automatic step(input logic [N-1:0] r, input logic rdy,
                      input logic [N-1:0] eg, input string nm);
    @(posedge clk);
    #2;
    req = r;
    out_ready = rdy;
    #1;
    chk({nm, " grant"}, 32'(grant), 32'(eg));
    for (int i = 0; i < N; i++)
      if (eg[i]) exp_q.push_back({S'(i), din[i*T +: T]});
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: unexpected ctrl=%0d out=%0h",
                 ctrl, dout);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ctrl, dout} !== mon_e) begin
          n_fail++;
          $display("FAIL scoreboard: got ctrl=%0d out=%0h expected ctrl=%0d out=%0h",
                   ctrl, dout, mon_e[S+T-1:T], mon_e[T-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    req = 4'hF;
    out_ready = 1'b1;
    #3;
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst valid", 32'(out_valid), 32'h0);
    chk("rst out", 32'(dout), 32'h0);
    chk("rst ctrl", 32'(ctrl), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    req = '0;
    out_ready = 1'b0;

    din = 32'h0000_00A5;
    step(4'b0001, 1'b1, 4'b0001, "single load");
    step(4'b0000, 1'b1, 4'b0000, "drain");
    chk("latency valid", 32'(out_valid), 32'h1);
    chk("latency out", 32'(dout), 32'hA5);
    step(4'b0000, 1'b0, 4'b0000, "idle");
    chk("drain valid", 32'(out_valid), 32'h0);
    chk("drain out hold", 32'(dout), 32'hA5);
    chk("drain ctrl hold", 32'(ctrl), 32'h0);

    din = 32'h0000_7700;
    step(4'b0010, 1'b1, 4'b0010, "pre-reset load");
    step(4'b0000, 1'b0, 4'b0000, "pre-reset hold");
    chk("held valid", 32'(out_valid), 32'h1);
    chk("held out", 32'(dout), 32'h77);
    req = 4'hF;
    reset = 1'b1;
    #1;
    chk("async valid", 32'(out_valid), 32'h0);
    chk("async out", 32'(dout), 32'h0);
    chk("async ctrl", 32'(ctrl), 32'h0);
    chk("async grant", 32'(grant), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    req = '0;

    din = 32'h1312_1110;
    for (int k = 0; k < 5; k++)
      step(4'hF, 1'b1, 4'(1 << (k % 4)), "rr all");
    step(4'hF, 1'b1, 4'b0010, "stall pre");
    for (int k = 0; k < 3; k++) begin
      step(4'hF, 1'b0, 4'b0000, "stall");
      chk("stall out", 32'(dout), 32'h11);
      chk("stall valid", 32'(out_valid), 32'h1);
    end
    step(4'hF, 1'b1, 4'b0100, "resume");
    step(4'b0101, 1'b1, 4'b0001, "wrap");
    step(4'b0101, 1'b1, 4'b0100, "wrap next");
    step(4'b0100, 1'b1, 4'b0100, "persist a");
    step(4'b0100, 1'b1, 4'b0100, "persist b");
    step(4'b0000, 1'b1, 4'b0000, "final drain");
    step(4'b0000, 1'b1, 4'b0000, "empty rdy");
    chk("end valid", 32'(out_valid), 32'h0);
    chk("end out", 32'(dout), 32'h12);
    chk("end ctrl", 32'(ctrl), 32'h2);
    step(4'b0000, 1'b0, 4'b0000, "end idle");
    chk("queue empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
